// File: rtl/srl_fifo_ctrl_if.sv
// srl_fifo_ctrl_if
//   Producer/consumer handshake bundle for the SRL FIFO controller.
//   Signals:
//     if_write_ce, if_write, if_din  producer side requests and data
//     if_full_n                      1 = space available
//     if_read_ce, if_read            consumer side requests
//     if_dout                        head-of-queue data
//     if_empty_n                     1 = data available
//   Modports:
//     master  the producer/consumer pair driving requests
//     slave   the FIFO controller answering with flags and data
interface srl_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 1
);
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;

  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_dout, if_empty_n
  );

  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_dout, if_empty_n
  );
endinterface

// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl
//   Control path for a shift-register FIFO. Tracks occupancy, produces the
//   full/empty/almost-full flags and drives the write-enable and read index of
//   an external SRL. Payload is never stored here; it passes straight through.
//   Ports:
//     clk          rising-edge clock
//     reset_n      asynchronous reset, active low
//     bus          handshake bundle (slave modport)
//     almost_full  registered, count >= AF_LEVEL
//     usedw        current occupancy 0..DEPTH
//     sr_we        SRL shift enable (combinational, equals accepted push)
//     sr_addr      SRL read index of the oldest entry (registered)
//     sr_din       data into the SRL (= bus.if_din)
//     sr_dout      data out of the SRL
module srl_fifo_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2,
  parameter int AF_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  srl_fifo_ctrl_if.slave        bus,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  sr_we,
  output logic [ADDR_WIDTH-1:0] sr_addr,
  output logic [DATA_WIDTH-1:0] sr_din,
  input  logic [DATA_WIDTH-1:0] sr_dout
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   count, count_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic                  af_q, af_next;
  logic                  full_n, empty_n;
  logic                  push, pop;

  assign full_n  = (state != FULL);
  assign empty_n = (state != EMPTY);

  // Requests are only accepted when the matching flag allows them. The
  // reset_n term keeps the SRL from shifting while reset is held, since the
  // full flag reads "space available" during reset.
  assign push = bus.if_write & bus.if_write_ce & full_n & reset_n;
  assign pop  = bus.if_read  & bus.if_read_ce  & empty_n;

  // Next occupancy, state, read index and almost-full flag. A simultaneous
  // push and pop leaves the head at the same SRL index, so the index holds.
  always_comb begin
    count_next = count;
    state_next = state;
    addr_next  = addr_q;
    af_next    = af_q;

    unique case ({push, pop})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;
    endcase

    unique case (state)
      EMPTY:   if (count_next != '0) state_next = ACTIVE;
      ACTIVE: begin
        if (count_next == '0)          state_next = EMPTY;
        else if (count_next == DEPTH_C) state_next = FULL;
      end
      FULL:    if (count_next != DEPTH_C) state_next = ACTIVE;
      default: state_next = EMPTY;
    endcase

    addr_next = (count_next == '0) ? '0 : ADDR_WIDTH'(count_next - ONE_C);
    af_next   = (count_next >= AF_C);
  end

  // State and status registers; reset discards all contents logically.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      count  <= '0;
      addr_q <= '0;
      af_q   <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      addr_q <= addr_next;
      af_q   <= af_next;
    end
  end

  assign bus.if_full_n  = full_n;
  assign bus.if_empty_n = empty_n;
  assign bus.if_dout    = sr_dout;
  assign almost_full    = af_q;
  assign usedw          = count;
  assign sr_we          = push;
  assign sr_addr        = addr_q;
  assign sr_din         = bus.if_din;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// tb_srl_fifo_ctrl
//   Self-checking bench for srl_fifo_ctrl with DEPTH=4, ADDR_WIDTH=2,
//   AF_LEVEL=3, DATA_WIDTH=8 and a behavioural SRL attached.
module tb_srl_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DP = 4;
  localparam int AF = 3;

  logic          clk;
  logic          reset_n;
  logic          almost_full;
  logic [AW:0]   usedw;
  logic          sr_we;
  logic [AW-1:0] sr_addr;
  logic [DW-1:0] sr_din;
  logic [DW-1:0] sr_dout;

  srl_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus_if ();

  srl_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .AF_LEVEL(AF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus_if.slave),
    .almost_full (almost_full),
    .usedw       (usedw),
    .sr_we       (sr_we),
    .sr_addr     (sr_addr),
    .sr_din      (sr_din),
    .sr_dout     (sr_dout)
  );

  // Behavioural SRL: index 0 holds the newest entry.
  logic [DW-1:0] srl_mem [DP];

  always_ff @(posedge clk) begin
    if (sr_we) begin
      srl_mem[0] <= sr_din;
      for (int k = 1; k < DP; k++) srl_mem[k] <= srl_mem[k-1];
    end
  end

  assign sr_dout = srl_mem[sr_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          wce;
    logic          rd;
    logic          rce;
    logic [DW-1:0] din;
    logic          exp_we;
    logic [AW:0]   exp_usedw;
    logic          exp_full_n;
    logic          exp_empty_n;
    logic          exp_af;
    logic [AW-1:0] exp_addr;
    logic          chk_dout;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vecs[$];
  int   testsRun;
  int   testsFailed;
  int   resumeIdx;

  task automatic addVec(input logic wr, wce, rd, rce, input logic [DW-1:0] din,
                        input logic we, input int uw, input logic fn, en, af,
                        input int addr, input logic cd, input logic [DW-1:0] dout);
    vec_t v;
    v.wr = wr; v.wce = wce; v.rd = rd; v.rce = rce; v.din = din;
    v.exp_we = we; v.exp_usedw = (AW+1)'(uw); v.exp_full_n = fn;
    v.exp_empty_n = en; v.exp_af = af; v.exp_addr = AW'(addr);
    v.chk_dout = cd; v.exp_dout = dout;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    bus_if.if_write    = v.wr;
    bus_if.if_write_ce = v.wce;
    bus_if.if_read     = v.rd;
    bus_if.if_read_ce  = v.rce;
    bus_if.if_din      = v.din;
    #1;
    checkOutput($sformatf("v%0d sr_we", idx), 32'(sr_we), 32'(v.exp_we));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d usedw", idx), 32'(usedw), 32'(v.exp_usedw));
    checkOutput($sformatf("v%0d full_n", idx), 32'(bus_if.if_full_n), 32'(v.exp_full_n));
    checkOutput($sformatf("v%0d empty_n", idx), 32'(bus_if.if_empty_n), 32'(v.exp_empty_n));
    checkOutput($sformatf("v%0d almost_full", idx), 32'(almost_full), 32'(v.exp_af));
    checkOutput($sformatf("v%0d sr_addr", idx), 32'(sr_addr), 32'(v.exp_addr));
    if (v.chk_dout)
      checkOutput($sformatf("v%0d dout", idx), 32'(bus_if.if_dout), 32'(v.exp_dout));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " usedw"}, 32'(usedw), 32'd0);
    checkOutput({tag, " full_n"}, 32'(bus_if.if_full_n), 32'd1);
    checkOutput({tag, " empty_n"}, 32'(bus_if.if_empty_n), 32'd0);
    checkOutput({tag, " almost_full"}, 32'(almost_full), 32'd0);
    checkOutput({tag, " sr_addr"}, 32'(sr_addr), 32'd0);
    checkOutput({tag, " sr_we"}, 32'(sr_we), 32'd0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    //      wr wce rd rce din    we uw fn en af ad cd dout
    // idle after reset
    addVec(0, 1, 0, 1, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    addVec(0, 1, 0, 1, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    // write with clock enable low is ignored
    addVec(1, 0, 0, 1, 8'h55, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    // fill A1..A4
    addVec(1, 1, 0, 1, 8'hA1, 1, 1, 1, 1, 0, 0, 1, 8'hA1);
    addVec(1, 1, 0, 1, 8'hA2, 1, 2, 1, 1, 0, 1, 1, 8'hA1);
    addVec(1, 1, 0, 1, 8'hA3, 1, 3, 1, 1, 1, 2, 1, 8'hA1);
    addVec(1, 1, 0, 1, 8'hA4, 1, 4, 0, 1, 1, 3, 1, 8'hA1);
    // push while full is ignored
    addVec(1, 1, 0, 1, 8'hA5, 0, 4, 0, 1, 1, 3, 1, 8'hA1);
    // drain in order
    addVec(0, 1, 1, 1, 8'h00, 0, 3, 1, 1, 1, 2, 1, 8'hA2);
    addVec(0, 1, 1, 1, 8'h00, 0, 2, 1, 1, 0, 1, 1, 8'hA3);
    addVec(0, 1, 1, 1, 8'h00, 0, 1, 1, 1, 0, 0, 1, 8'hA4);
    addVec(0, 1, 1, 1, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    // pop while empty is ignored
    addVec(0, 1, 1, 1, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    // push+pop in EMPTY acts as push only
    addVec(1, 1, 1, 1, 8'hC1, 1, 1, 1, 1, 0, 0, 1, 8'hC1);
    addVec(0, 1, 1, 1, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    // B1,B2 then steady push+pop
    addVec(1, 1, 0, 1, 8'hB1, 1, 1, 1, 1, 0, 0, 1, 8'hB1);
    addVec(1, 1, 0, 1, 8'hB2, 1, 2, 1, 1, 0, 1, 1, 8'hB1);
    addVec(1, 1, 1, 1, 8'hB3, 1, 2, 1, 1, 0, 1, 1, 8'hB2);
    addVec(1, 1, 1, 1, 8'hB4, 1, 2, 1, 1, 0, 1, 1, 8'hB3);
    addVec(1, 1, 1, 1, 8'hB5, 1, 2, 1, 1, 0, 1, 1, 8'hB4);
    addVec(1, 1, 1, 1, 8'hB6, 1, 2, 1, 1, 0, 1, 1, 8'hB5);
    addVec(1, 1, 1, 1, 8'hB7, 1, 2, 1, 1, 0, 1, 1, 8'hB6);
    // read with clock enable low is ignored
    addVec(0, 1, 1, 0, 8'h00, 0, 2, 1, 1, 0, 1, 1, 8'hB6);
    // third entry, then reset mid-operation
    addVec(1, 1, 0, 1, 8'hB8, 1, 3, 1, 1, 1, 2, 1, 8'hB6);
    resumeIdx = vecs.size();
    // after reset: D1..D4, then push+pop in FULL acts as pop only
    addVec(1, 1, 0, 1, 8'hD1, 1, 1, 1, 1, 0, 0, 1, 8'hD1);
    addVec(1, 1, 0, 1, 8'hD2, 1, 2, 1, 1, 0, 1, 1, 8'hD1);
    addVec(1, 1, 0, 1, 8'hD3, 1, 3, 1, 1, 1, 2, 1, 8'hD1);
    addVec(1, 1, 0, 1, 8'hD4, 1, 4, 0, 1, 1, 3, 1, 8'hD1);
    addVec(1, 1, 1, 1, 8'hE1, 0, 3, 1, 1, 1, 2, 1, 8'hD2);

    bus_if.if_write    = 1'b0;
    bus_if.if_write_ce = 1'b0;
    bus_if.if_read     = 1'b0;
    bus_if.if_read_ce  = 1'b0;
    bus_if.if_din      = '0;
    reset_n            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < resumeIdx; i++) applyStimulus(i);

    // Asynchronous reset in the middle of a cycle with three entries held,
    // while a write is still being requested.
    #2;
    bus_if.if_write    = 1'b1;
    bus_if.if_write_ce = 1'b1;
    bus_if.if_din      = 8'hEE;
    reset_n            = 1'b0;
    #1;
    checkResetState("midreset");
    @(posedge clk);
    #1;
    checkResetState("midreset hold");
    @(negedge clk);
    bus_if.if_write = 1'b0;
    reset_n         = 1'b1;

    for (int i = resumeIdx; i < vecs.size(); i++) applyStimulus(i);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
